// File: rtl/ram_pkg.sv
// Shared defaults and FSM state encoding for the RAM built-in self-test.
package ram_pkg;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/ram_bist_if.sv
// RAM access bus driven by the BIST (master) towards a single-port RAM (slave).
interface ram_bist_if
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);
  logic              ram_ena;
  logic              ram_wena;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output ram_ena, ram_wena, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport slave (
    input  ram_ena, ram_wena, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/ram_bist_patgen.sv
// Expected test word for an address: seed + addr, optionally inverted.
module ram_bist_patgen
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] seed,
  input  logic              pat_inv,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] pattern
);
  logic [DATA_W-1:0] sum;

  always_comb begin
    sum     = seed + DATA_W'(addr);
    pattern = pat_inv ? ~sum : sum;
  end
endmodule

// File: rtl/ram_bist.sv
// RAM BIST: writes a seed-based pattern to every word, reads it back, and
// reports mismatch count, first failing address and an overall pass flag.
module ram_bist
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  input  logic              pat_inv,
  ram_bist_if.master        ram,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] first_err_addr
);
  localparam int unsigned CNT_W = ADDR_W + 1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] seed_q;
  logic              inv_q;
  logic [DATA_W-1:0] exp_word;
  logic              last_addr;
  logic              mismatch;

  ram_bist_patgen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_patgen (
    .seed    (seed_q),
    .pat_inv (inv_q),
    .addr    (addr),
    .pattern (exp_word)
  );

  assign last_addr    = (addr == ADDR_W'(DEPTH - 1));
  assign ram.ram_addr = addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    ram.ram_ena   = 1'b0;
    ram.ram_wena  = 1'b0;
    ram.ram_wdata = '0;
    busy          = 1'b0;
    done          = 1'b0;
    mismatch      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = WRITE;
      end
      WRITE: begin
        ram.ram_ena   = 1'b1;
        ram.ram_wena  = 1'b1;
        ram.ram_wdata = exp_word;
        busy          = 1'b1;
        if (last_addr) state_nxt = READ;
      end
      READ: begin
        ram.ram_ena = 1'b1;
        busy        = 1'b1;
        // Case inequality so undriven or unknown read bits count as errors.
        mismatch    = (ram.ram_rdata !== exp_word);
        if (last_addr) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr           <= '0;
      seed_q         <= '0;
      inv_q          <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      pass           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            seed_q         <= seed;
            inv_q          <= pat_inv;
            err_cnt        <= '0;
            first_err_addr <= '0;
            pass           <= 1'b0;
            addr           <= '0;
          end
        end
        WRITE: addr <= last_addr ? '0 : addr + 1'b1;
        READ: begin
          addr <= last_addr ? '0 : addr + 1'b1;
          if (mismatch) begin
            if (err_cnt != CNT_W'(DEPTH)) err_cnt <= err_cnt + 1'b1;
            if (err_cnt == '0) first_err_addr <= addr;
          end
          // Fold in the final word's compare so pass is valid alongside done.
          if (last_addr) pass <= (err_cnt == '0) && !mismatch;
        end
        default: ;
      endcase
    end
  end
endmodule
